// File: rtl/apb_master.sv
// APB (v3-style) requester: turns single-beat local commands into APB transfers.
// Handles slave wait states and aborts a transfer that stalls past TIMEOUT cycles.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              write_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              selx_nx, enable_nx;
  logic              rsp_valid_nx, rsp_slverr_nx, rsp_timeout_nx;
  logic [DATA_W-1:0] rsp_rdata_nx;

  // Held low during reset so the requester never looks ready while resetting.
  assign cmd_ready = (state == IDLE) && !P_rst;

  always_comb begin
    state_nx       = state;
    wait_cnt_nx    = wait_cnt;
    addr_nx        = P_addr;
    write_nx       = P_write;
    wdata_nx       = P_wdata;
    selx_nx        = 1'b0;
    enable_nx      = 1'b0;
    rsp_valid_nx   = 1'b0;
    rsp_rdata_nx   = rsp_rdata;
    rsp_slverr_nx  = rsp_slverr;
    rsp_timeout_nx = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = SETUP;
          addr_nx  = cmd_addr;
          write_nx = cmd_write;
          wdata_nx = cmd_wdata;
          selx_nx  = 1'b1;
        end
      end
      SETUP: begin
        state_nx    = ACCESS;
        wait_cnt_nx = '0;
        selx_nx     = 1'b1;
        enable_nx   = 1'b1;
      end
      ACCESS: begin
        if (P_ready) begin
          state_nx       = IDLE;
          rsp_valid_nx   = 1'b1;
          rsp_rdata_nx   = P_write ? '0 : P_rdata;
          rsp_slverr_nx  = P_slverr;
          rsp_timeout_nx = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          // Stalled for the full budget: abort and report as an error.
          state_nx       = IDLE;
          rsp_valid_nx   = 1'b1;
          rsp_rdata_nx   = '0;
          rsp_slverr_nx  = 1'b1;
          rsp_timeout_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
          selx_nx     = 1'b1;
          enable_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      P_addr      <= '0;
      P_write     <= 1'b0;
      P_wdata     <= '0;
      P_selx      <= 1'b0;
      P_enable    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      P_addr      <= addr_nx;
      P_write     <= write_nx;
      P_wdata     <= wdata_nx;
      P_selx      <= selx_nx;
      P_enable    <= enable_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_slverr  <= rsp_slverr_nx;
      rsp_timeout <= rsp_timeout_nx;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a driver pushes expected responses computed
// from the transfer rules, a negedge monitor pops and compares them.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          P_clk = 1'b0;
  logic          P_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] P_addr;
  logic          P_selx;
  logic          P_enable;
  logic          P_write;
  logic [DW-1:0] P_wdata;
  logic          P_ready = 1'b0;
  logic          P_slverr = 1'b0;
  logic [DW-1:0] P_rdata = '0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
    .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  always #5 P_clk = ~P_clk;

  int cyc = 0;
  always @(posedge P_clk) cyc++;

  typedef struct {
    int            edgeE;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
    int            selN;
    int            enN;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  int            planWaits = 0;
  logic          planErr = 1'b0;
  logic [DW-1:0] planRdata = '0;
  logic [AW-1:0] curAddr = '0;
  logic          curWrite = 1'b0;
  logic [DW-1:0] curWdata = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Slave model: ready after planWaits ACCESS cycles, junk on every ignored cycle.
  int accCnt = 0;
  always @(negedge P_clk) begin
    if (P_selx && P_enable) begin
      if (accCnt == planWaits) begin
        P_ready  = 1'b1;
        P_slverr = planErr;
        P_rdata  = planRdata;
      end else begin
        P_ready  = 1'b0;
        P_slverr = 1'($urandom_range(0, 1));
        P_rdata  = $urandom;
      end
      accCnt++;
    end else begin
      accCnt   = 0;
      P_ready  = 1'($urandom_range(0, 1));
      P_slverr = 1'($urandom_range(0, 1));
      P_rdata  = $urandom;
    end
  end

  // Monitor: bus stability, selx/enable lengths, response contents and timing.
  int            selN = 0;
  int            enN = 0;
  logic [DW-1:0] lastRdata = '0;
  logic          lastErr = 1'b0;
  logic          lastTmo = 1'b0;
  exp_t          monE;
  always @(negedge P_clk) begin
    if (P_rst) begin
      selN = 0; enN = 0;
      lastRdata = '0; lastErr = 1'b0; lastTmo = 1'b0;
    end else begin
      if (P_selx) begin
        selN++;
        checkOutput("bus_addr", P_addr, curAddr);
        checkOutput("bus_write", P_write, curWrite);
        checkOutput("bus_wdata", P_wdata, curWdata);
      end
      if (P_enable) begin
        enN++;
        checkOutput("enable_without_sel", P_selx, 1);
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_rsp", rsp_valid, 0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("rsp_edge", cyc, monE.edgeE);
          checkOutput("rsp_rdata", rsp_rdata, monE.rdata);
          checkOutput("rsp_slverr", rsp_slverr, monE.slverr);
          checkOutput("rsp_timeout", rsp_timeout, monE.tmo);
          checkOutput("selx_cycles", selN, monE.selN);
          checkOutput("enable_cycles", enN, monE.enN);
          lastRdata = monE.rdata; lastErr = monE.slverr; lastTmo = monE.tmo;
        end
        selN = 0; enN = 0;
      end else begin
        checkOutput("hold_rdata", rsp_rdata, lastRdata);
        checkOutput("hold_slverr", rsp_slverr, lastErr);
        checkOutput("hold_timeout", rsp_timeout, lastTmo);
      end
    end
  end

  // Presents one command, waits for its accept and records the expected response.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int waits, input logic err, input logic [DW-1:0] rd,
                               output int accEdge, output int rspEdge);
    int   n;
    int   k;
    exp_t e;
    @(negedge P_clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge P_clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      accEdge = -1; rspEdge = -1;
      return;
    end
    planWaits = waits; planErr = err; planRdata = rd;
    curAddr = a; curWrite = w; curWdata = d;
    accEdge = cyc + 1;
    k = (waits > TO - 1) ? TO - 1 : waits;
    e.tmo    = (waits >= TO);
    e.slverr = e.tmo ? 1'b1 : err;
    e.rdata  = (e.tmo || w) ? '0 : rd;
    e.edgeE  = accEdge + 2 + k;
    e.selN   = k + 2;
    e.enN    = k + 1;
    sbq.push_back(e);
    rspEdge = e.edgeE;
    @(posedge P_clk);
  endtask

  task automatic idleBus();
    @(negedge P_clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int a1, e1, a2, e2, n, waits;
    $display("[TB] start");
    repeat (3) @(negedge P_clk);
    checkOutput("rst_selx", P_selx, 0);
    checkOutput("rst_enable", P_enable, 0);
    checkOutput("rst_addr", P_addr, 0);
    checkOutput("rst_wdata", P_wdata, 0);
    checkOutput("rst_write", P_write, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_flags", {rsp_slverr, rsp_timeout}, 0);
    P_rst = 1'b0;
    @(negedge P_clk);
    checkOutput("ready_after_release", cmd_ready, 1);

    applyStimulus(1'b1, 32'h4, 32'h7, 0, 1'b0, 32'hdead, a1, e1);
    idleBus();
    applyStimulus(1'b0, 32'h2, 32'h0, 2, 1'b0, 32'h55, a1, e1);
    idleBus();
    applyStimulus(1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h1234, a1, e1);
    idleBus();
    applyStimulus(1'b0, 32'h20, 32'h0, 1000, 1'b0, 32'h9999, a1, e1);
    idleBus();
    repeat (2) @(negedge P_clk);

    applyStimulus(1'b1, 32'h1, 32'haa, 0, 1'b0, 32'h0, a1, e1);
    applyStimulus(1'b1, 32'h2, 32'hbb, 0, 1'b0, 32'h0, a2, e2);
    idleBus();
    checkOutput("b2b_accept_edge", a2, e1 + 1);

    for (int i = 0; i < 40; i++) begin
      waits = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, 4));
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, waits,
                    1'($urandom_range(0, 1)), $urandom, a1, e1);
      if ($urandom_range(0, 1) == 1) begin
        idleBus();
        repeat ($urandom_range(0, 3)) @(negedge P_clk);
      end
    end
    idleBus();
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge P_clk);
      n++;
    end
    checkOutput("drain", sbq.size(), 0);

    // Reset in the middle of a waited read: no response may follow.
    applyStimulus(1'b0, 32'h30, 32'h0, 10, 1'b1, 32'h77, a1, e1);
    idleBus();
    repeat (3) @(negedge P_clk);
    #2;
    P_rst = 1'b1;
    sbq.delete();
    #1;
    checkOutput("midrst_selx", P_selx, 0);
    checkOutput("midrst_enable", P_enable, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 0);
    checkOutput("midrst_rsp_flags", {rsp_slverr, rsp_timeout}, 0);
    checkOutput("midrst_addr", P_addr, 0);
    repeat (2) @(negedge P_clk);
    P_rst = 1'b0;
    @(negedge P_clk);
    checkOutput("midrst_ready_after_release", cmd_ready, 1);
    repeat (20) @(negedge P_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Upstream APB requester that turns single-beat commands from a local controller into AMBA APB (v3-style) transfers. It drives the `P_*` bus into the `AMBA_APB` slave and returns read data and error status on a one-cycle response strobe. It handles slave wait states through `P_ready` and aborts any transfer that stalls past a programmable timeout.

## Interface
**Parameters**
- `ADDR_W`, default 32: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum ACCESS cycles before abort. Legal range 1..255.

**Ports**
- `P_clk` in 1: single clock; all state changes on its rising edge.
- `P_rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on any edge where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: transfer address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse at transfer completion. There is no backpressure.
- `rsp_rdata` out DATA_W: captured `P_rdata`. Forced to 0 for writes and timeouts.
- `rsp_slverr` out 1: slave error or timeout.
- `rsp_timeout` out 1: transfer was aborted by timeout.
- `P_addr` out ADDR_W, `P_selx` out 1, `P_enable` out 1, `P_write` out 1, `P_wdata` out DATA_W: APB request side.
- `P_ready` in 1, `P_slverr` in 1, `P_rdata` in DATA_W: APB completion side.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP on command accept. The command is registered onto `P_addr`, `P_write` and `P_wdata`.
  - SETUP → ACCESS unconditionally after one cycle.
  - ACCESS → IDLE when `P_ready`=1, or on timeout.
- All APB outputs are registered.
  - `P_selx`=1 in SETUP and ACCESS only.
  - `P_enable`=1 in ACCESS only.
- `P_addr`, `P_write` and `P_wdata` are stable from SETUP through the last ACCESS cycle. In IDLE they hold their last value; they do not toggle or clear.
- Wait counter (width ceil(log2(TIMEOUT+1))):
  - Cleared on entry to ACCESS.
  - Increments on each ACCESS edge where `P_ready`=0.
  - If `P_ready`=0 and the counter equals TIMEOUT-1, the transfer aborts. ACCESS therefore lasts at most TIMEOUT cycles.
- Completion with `P_ready`=1:
  - `rsp_slverr` = `P_slverr`.
  - `rsp_rdata` = `P_rdata` for reads, 0 for writes.
  - `rsp_timeout` = 0.
- Timeout completion: `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- `P_ready` and `P_slverr` are ignored outside ACCESS.
- Response fields are valid only while `rsp_valid`=1. They hold their value until the next response.
- Reset, including mid-transfer: all outputs go to 0 immediately, the state goes to IDLE, and the counter clears. The in-flight transfer is dropped and produces no response. `cmd_ready` rises once reset deasserts.

## Timing
- Reset values: `P_addr`, `P_wdata`, `rsp_rdata` = 0; `P_selx`, `P_enable`, `P_write`, `rsp_valid`, `rsp_slverr`, `rsp_timeout` = 0; `cmd_ready` = 1 after reset release.
- `cmd_ready` is decoded from the state register: high in IDLE, low in SETUP and ACCESS.
- Cycle numbering, with an accept at edge 0:
  - Edge 0: `P_selx`=1 (SETUP).
  - Edge 1: `P_enable`=1 (ACCESS).
  - First edge E ≥ 2 with `P_ready`=1 (or the timeout edge): `P_selx` and `P_enable` drop to 0, and `rsp_valid`=1 for the cycle after E.
- Zero-wait transfer: 3 cycles from accept to `rsp_valid`. Each slave wait state adds 1 cycle.
- Back-to-back commands: `cmd_ready` reasserts in the same cycle `rsp_valid` is high. The next accept can occur at the edge ending that cycle, so there is at least 1 IDLE cycle between transfers.
- A command presented in SETUP or ACCESS waits with `cmd_ready`=0. The command inputs must stay stable until accepted.

## Test plan
- **Zero-wait write:** `cmd_write`=1, `cmd_addr`=0x4, `cmd_wdata`=7, slave `P_ready`=1.
  - `P_selx` high exactly 2 cycles, `P_enable` high exactly 1 cycle, `P_addr`=4 and `P_wdata`=7 throughout.
  - `rsp_valid` pulses 3 cycles after accept with `rsp_slverr`=0 and `rsp_rdata`=0.
- **Read with 2 wait states:** `cmd_addr`=0x2; slave holds `P_ready`=0 for 2 ACCESS cycles, then 1 with `P_rdata`=0x55.
  - `P_enable` high 3 cycles.
  - `rsp_valid` 5 cycles after accept with `rsp_rdata`=0x55.
- **Slave error:** read completes with `P_ready`=1 and `P_slverr`=1.
  - `rsp_slverr`=1, `rsp_timeout`=0.
- **Timeout:** `TIMEOUT`=16 and `P_ready` held at 0.
  - `P_enable` high exactly 16 cycles.
  - Then `rsp_valid`=1 with `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- **Back-to-back:** write to 0x1 then write to 0x2 with `cmd_valid` held high and a zero-wait slave.
  - Second accept coincides with the cycle of the first `rsp_valid`.
  - `P_selx` goes low for exactly 1 cycle between the two transfers.
- **Reset mid-ACCESS:** assert `P_rst` asynchronously during a waited read.
  - `P_selx`, `P_enable` and all `rsp_*` outputs go to 0 immediately.
  - No `rsp_valid` pulse occurs after release.
  - `cmd_ready`=1 on the first cycle after release.
